// File: rtl/uart_tx_parity.sv
// UART transmitter: start bit, 8 data bits LSB first, configurable-sense parity bit, 1 or 2 stop bits.
// Bit time is a run-time clocks-per-bit value latched at frame accept.
module uart_tx_parity #(
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] count,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       serial_out,
  output logic       tx_active,
  output logic       tx_done,
  output logic       even_parity
);

  localparam logic ODD_SENSE = (PARITY_ODD != 0);
  localparam logic TWO_STOP  = (STOP_BITS == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state, state_n;
  logic [7:0] clk_cnt, clk_cnt_n;
  logic [7:0] bit_len, bit_len_n;
  logic [7:0] shift_reg, shift_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic       stop_idx, stop_idx_n;
  logic       serial_n, active_n, done_n, parity_n;
  logic       bit_end;
  logic       stop_last;

  assign bit_end   = (clk_cnt == bit_len - 8'd1);
  assign stop_last = !TWO_STOP || stop_idx;

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_n    = state;
    clk_cnt_n  = clk_cnt;
    bit_len_n  = bit_len;
    shift_n    = shift_reg;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    serial_n   = serial_out;
    active_n   = tx_active;
    done_n     = 1'b0;
    parity_n   = even_parity;

    if (state != IDLE) begin
      clk_cnt_n = bit_end ? '0 : clk_cnt + 8'd1;
    end

    case (state)
      IDLE: begin
        if (tx_start) begin
          shift_n    = data_in;
          bit_len_n  = (count == 8'd0) ? 8'd1 : count;
          parity_n   = ^data_in ^ ODD_SENSE;
          clk_cnt_n  = '0;
          bit_idx_n  = '0;
          stop_idx_n = 1'b0;
          serial_n   = 1'b0;
          active_n   = 1'b1;
          state_n    = START;
        end
      end
      START: begin
        if (bit_end) begin
          serial_n = shift_reg[0];
          state_n  = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n   = shift_reg >> 1;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            serial_n = even_parity;
            state_n  = PARITY;
          end else begin
            serial_n = shift_reg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          serial_n   = 1'b1;
          stop_idx_n = 1'b0;
          state_n    = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_last) begin
            active_n = 1'b0;
            done_n   = 1'b1;
            state_n  = IDLE;
          end else begin
            stop_idx_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_len     <= 8'd1;
      shift_reg   <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      serial_out  <= 1'b1;
      tx_active   <= 1'b0;
      tx_done     <= 1'b0;
      even_parity <= 1'b0;
    end else begin
      state       <= state_n;
      clk_cnt     <= clk_cnt_n;
      bit_len     <= bit_len_n;
      shift_reg   <= shift_n;
      bit_idx     <= bit_idx_n;
      stop_idx    <= stop_idx_n;
      serial_out  <= serial_n;
      tx_active   <= active_n;
      tx_done     <= done_n;
      even_parity <= parity_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_parity.sv
// Bench for uart_tx_parity: even/1-stop and odd/2-stop instances on shared stimulus,
// checked every cycle against a frame-level waveform model plus directed literal checks.
module tb_uart_tx_parity;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] count;
  logic       tx_start;
  logic [7:0] data_in;
  logic       serial_out, tx_active, tx_done, even_parity;
  logic       serial_odd, active_odd, done_odd, par_odd;

  int total = 0;
  int bad   = 0;

  uart_tx_parity #(.PARITY_ODD(0), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .count(count), .tx_start(tx_start), .data_in(data_in),
    .serial_out(serial_out), .tx_active(tx_active), .tx_done(tx_done), .even_parity(even_parity)
  );

  uart_tx_parity #(.PARITY_ODD(1), .STOP_BITS(2)) dut_odd (
    .clk(clk), .rst(rst), .count(count), .tx_start(tx_start), .data_in(data_in),
    .serial_out(serial_odd), .tx_active(active_odd), .tx_done(done_odd), .even_parity(par_odd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one queue entry per clock cycle of expected outputs after each edge.
  typedef struct packed {
    logic ser;
    logic act;
    logic done;
  } exp_t;

  localparam exp_t IDLE_E = '{ser: 1'b1, act: 1'b0, done: 1'b0};

  exp_t q0[$];
  exp_t q1[$];
  logic exp_par0 = 1'b0;
  logic exp_par1 = 1'b0;

  task automatic model_accept(input int inst, input logic [7:0] d, input logic [7:0] c);
    int   bl;
    logic par;
    logic bits[$];
    exp_t e;
    bl  = (c == 8'd0) ? 1 : int'(c);
    par = ^d ^ (inst == 1);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    bits.push_back(par);
    bits.push_back(1'b1);
    if (inst == 1) bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int k = 0; k < bl; k++) begin
        e = '{ser: bits[b], act: 1'b1, done: 1'b0};
        if (inst == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    e = '{ser: 1'b1, act: 1'b0, done: 1'b1};
    if (inst == 0) begin q0.push_back(e); exp_par0 = par; end
    else begin q1.push_back(e); exp_par1 = par; end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q0.delete();
      q1.delete();
      exp_par0 = 1'b0;
      exp_par1 = 1'b0;
    end else begin
      bit idle0, idle1;
      idle0 = (q0.size() == 0) || q0[0].done;
      idle1 = (q1.size() == 0) || q1[0].done;
      if (q0.size() > 0) void'(q0.pop_front());
      if (q1.size() > 0) void'(q1.pop_front());
      if (idle0 && tx_start) model_accept(0, data_in, count);
      if (idle1 && tx_start) model_accept(1, data_in, count);
    end
  end

  always @(negedge clk) begin
    exp_t e0, e1;
    e0 = (q0.size() > 0) ? q0[0] : IDLE_E;
    e1 = (q1.size() > 0) ? q1[0] : IDLE_E;
    check("even_serial", serial_out, e0.ser);
    check("even_active", tx_active, e0.act);
    check("even_done", tx_done, e0.done);
    check("even_parity_out", even_parity, exp_par0);
    check("odd_serial", serial_odd, e1.ser);
    check("odd_active", active_odd, e1.act);
    check("odd_done", done_odd, e1.done);
    check("odd_parity_out", par_odd, exp_par1);
  end

  // Sends one frame and decodes it like a mid-bit-sampling receiver.
  task automatic run_frame(input logic [7:0] d, input logic [7:0] c,
                           output int act_len, output int done_lat,
                           output logic [7:0] rx, output logic rxp, output logic rxp_odd);
    int bl;
    int i;
    bl       = (c == 8'd0) ? 1 : int'(c);
    act_len  = 0;
    done_lat = -1;
    rx       = '0;
    rxp      = 1'bx;
    rxp_odd  = 1'bx;
    @(negedge clk);
    tx_start = 1'b1;
    data_in  = d;
    count    = c;
    @(negedge clk);
    tx_start = 1'b0;
    data_in  = ~d;
    count    = c + 8'd3;
    for (int n = 0; n < 4000; n++) begin
      if (tx_active) act_len++;
      if (n % bl == bl / 2) begin
        i = n / bl;
        if (i >= 1 && i <= 8) rx[i-1] = serial_out;
        if (i == 9) begin
          rxp     = serial_out;
          rxp_odd = serial_odd;
        end
      end
      if (tx_done) begin
        done_lat = n + 1;
        break;
      end
      @(negedge clk);
    end
    if (done_lat < 0) check("frame_timeout", 0, 1);
    for (int n = 0; n < 600 && active_odd; n++) @(negedge clk);
    if (active_odd) check("odd_frame_timeout", 0, 1);
    @(negedge clk);
  endtask

  int         alen, dlat, dones, gap;
  logic [7:0] rxb;
  logic       rp, rpo;
  bit         second;

  logic [7:0] pvals [4] = '{8'h01, 8'h07, 8'hFF, 8'h00};
  logic       pexp  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst      = 1'b0;
    tx_start = 1'b0;
    data_in  = '0;
    count    = '0;
    repeat (3) @(negedge clk);
    check("reset_serial", serial_out, 1);
    check("reset_active", tx_active, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5 at 4 clocks per bit
    run_frame(8'hA5, 8'd4, alen, dlat, rxb, rp, rpo);
    check("a5_done_latency", dlat, 45);
    check("a5_active_len", alen, 44);
    check("a5_byte", rxb, 8'hA5);
    check("a5_parity_bit", rp, 0);
    check("a5_odd_parity_bit", rpo, 1);
    check("a5_even_parity_reg", even_parity, 0);
    check("a5_odd_parity_reg", par_odd, 1);

    // parity table at 50 clocks per bit
    for (int k = 0; k < 4; k++) begin
      run_frame(pvals[k], 8'd50, alen, dlat, rxb, rp, rpo);
      check("par_byte", rxb, pvals[k]);
      check("par_even_bit", rp, pexp[k]);
      check("par_odd_bit", rpo, !pexp[k]);
      check("par_even_reg", even_parity, pexp[k]);
      check("par_odd_reg", par_odd, !pexp[k]);
    end

    // minimum and maximum bit length
    run_frame(8'h3C, 8'd0, alen, dlat, rxb, rp, rpo);
    check("count0_len", alen, 11);
    check("count0_byte", rxb, 8'h3C);
    run_frame(8'h3C, 8'd1, alen, dlat, rxb, rp, rpo);
    check("count1_len", alen, 11);
    check("count1_done_latency", dlat, 12);
    run_frame(8'hC3, 8'd255, alen, dlat, rxb, rp, rpo);
    check("count255_len", alen, 2805);
    check("count255_byte", rxb, 8'hC3);

    // request while busy
    @(negedge clk);
    tx_start = 1'b1; data_in = 8'h55; count = 8'd2;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (5) @(negedge clk);
    tx_start = 1'b1; data_in = 8'hAA;
    @(negedge clk);
    tx_start = 1'b0;
    dones = 0;
    for (int n = 0; n < 60; n++) begin
      if (tx_done) dones++;
      @(negedge clk);
    end
    check("busy_done_count", dones, 1);
    check("busy_idle_line", serial_out, 1);
    check("busy_idle_active", tx_active, 0);

    // back-to-back with tx_start held
    @(negedge clk);
    tx_start = 1'b1; data_in = 8'h12; count = 8'd3;
    @(negedge clk);
    data_in = 8'h34;
    dones = 0; gap = 0; second = 0;
    for (int n = 0; n < 200 && dones < 2; n++) begin
      if (tx_done) dones++;
      if (dones == 1 && !tx_active && !second) gap++;
      if (dones == 1 && tx_active && !second) begin
        second   = 1;
        tx_start = 1'b0;
      end
      @(negedge clk);
    end
    tx_start = 1'b0;
    check("b2b_done_count", dones, 2);
    check("b2b_gap", gap, 1);
    for (int n = 0; n < 100 && active_odd; n++) @(negedge clk);
    repeat (2) @(negedge clk);

    // reset during the parity bit
    @(negedge clk);
    tx_start = 1'b1; data_in = 8'h5A; count = 8'd4;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (37) @(negedge clk);
    check("pre_reset_serial", serial_out, 0);
    check("pre_reset_odd_parreg", par_odd, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_serial", serial_out, 1);
    check("rst_active", tx_active, 0);
    check("rst_done", tx_done, 0);
    check("rst_odd_serial", serial_odd, 1);
    check("rst_odd_parreg", par_odd, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_frame(8'h81, 8'd4, alen, dlat, rxb, rp, rpo);
    check("post_rst_byte", rxb, 8'h81);
    check("post_rst_parity", rp, 0);
    check("post_rst_odd_parity", rpo, 1);
    check("post_rst_done_latency", dlat, 45);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_parity.md
# uart_tx_parity

UART transmitter with even parity: serialises one 8-bit byte per request as start bit, 8 data bits LSB first, parity bit, then stop bit(s). Bit timing comes from a run-time clocks-per-bit value on `count`, the same value and meaning used by `uart_rx`. The block sits on the transmit side of the UART, and its `serial_out` connects directly to the `serial_in` of a `uart_rx` instance.

## Interface
- PARITY_ODD, 0, 0 = even parity (data ones plus parity bit is even); 1 = odd parity
- STOP_BITS, 1, number of stop bits, legal values 1 or 2
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- count  input  8  clocks per bit; latched when a frame is accepted; 0 is treated as 1
- tx_start  input  1  transmit request; sampled only in IDLE
- data_in  input  8  byte to send; latched with `tx_start`
- serial_out  output  1  serial line; idles high
- tx_active  output  1  high from the first start-bit cycle through the last stop-bit cycle
- tx_done  output  1  one-cycle pulse after the last stop-bit cycle
- even_parity  output  1  parity bit of the frame in flight, or of the last frame sent; registered at accept

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP.
- **IDLE:** on `tx_start`=1, latch the following, then go to START:
  - `data_in` into the shift register
  - `count` (0 becomes 1) into `bit_len`
  - parity = ^data_in ^ PARITY_ODD into `even_parity`
  - In IDLE, `tx_start`=0 leaves all state unchanged.
- **Bit counter:** `clk_cnt` runs 0..`bit_len`-1 in every non-IDLE state. A bit ends in the cycle where `clk_cnt` = `bit_len`-1. The counter then clears to 0.
- **START:** `serial_out`=0 for one bit time, then go to DATA.
- **DATA:** `serial_out` = shift_reg[0]. At each bit end:
  - shift right
  - increment `bit_idx`
  - after `bit_idx`=7 completes, go to PARITY
- **PARITY:** `serial_out` = `even_parity` for one bit time, then go to STOP.
- **STOP:** `serial_out`=1 for STOP_BITS bit times, then go to IDLE.
- **Busy requests:** `tx_start` outside IDLE is ignored. It is not queued, and latched data and parity do not change.
- **Input changes mid-frame:** changes on `data_in` or `count` during a frame have no effect.
- **Counter widths:** `clk_cnt` is 8 bits. `bit_len` = 255 must work with no wrap error.
- **Reset values** (async assert, any state; takes effect at once, including mid-frame):
  - state IDLE
  - `serial_out`=1, `tx_active`=0, `tx_done`=0, `even_parity`=0
  - `clk_cnt`, `bit_idx` and shift register all 0
  - A frame cut by reset is abandoned. The line returns high with no stop-bit completion.
  - Reset is released synchronously to `clk` by the system; nothing is accepted in the release cycle if `rst` is still low.

## Timing
- **Registered outputs:** all outputs come straight from flops; no combinational path from inputs to outputs.
- **Accept to start bit:** `tx_start` sampled high at edge k (IDLE) gives `serial_out`=0 and `tx_active`=1 from edge k+1.
- **Bit duration:** each bit lasts exactly `bit_len` cycles. Frame length is (10+STOP_BITS)·`bit_len` cycles.
- **End of frame:** at the edge after the last stop-bit cycle:
  - state goes to IDLE
  - `tx_active`=0
  - `tx_done`=1 for exactly one cycle
- **Back-to-back frames:**
  - `tx_start` high during the `tx_done` cycle is accepted, since that cycle is IDLE.
  - The next start bit begins one cycle later.
  - Minimum inter-frame idle is 1 cycle of `serial_out`=1 beyond the stop bit(s).
  - `tx_start` held high continuously sends frames back to back with this 1-cycle gap.
- **count = 1:** one cycle per bit, 11-cycle frame with STOP_BITS=1. No bit may be dropped or stretched.

## Test plan
- **0xA5, count=4, even:** `tx_start` pulse with `data_in`=0xA5.
  - Expected line: 0 ×4; data 1,0,1,0,0,1,0,1 (LSB first), ×4 each; parity 0 ×4; stop 1 ×4.
  - `tx_done` pulses 45 cycles after accept. `even_parity`=0.
- **Parity values:** 0x01→1, 0x07→1, 0xFF→0, 0x00→0 with PARITY_ODD=0; with PARITY_ODD=1 each value inverts.
  - Loop `serial_out` into `uart_rx` (same `count`=50). Check `data_byte` and `even_parity` match.
- **Minimum and maximum bit length:**
  - `count`=0 and `count`=1 each give an 11-cycle frame for 0x3C, every bit 1 cycle wide.
  - `count`=255 gives 2805 cycles.
- **Request while busy:** accept 0x55, then pulse `tx_start` with 0xAA mid-DATA.
  - Only the 0x55 frame appears.
  - Exactly one `tx_done`; line idle afterwards.
- **Back-to-back:** `tx_start` held high with 0x12 then 0x34, `count`=3.
  - Two frames, separated by exactly 1 idle cycle after the stop bit.
  - `tx_done` pulses twice.
- **Reset mid-frame:** drop `rst` during the parity bit.
  - `serial_out`=1, `tx_active`=0 and `tx_done`=0 immediately (asynchronous).
  - After release, a new 0x81 frame transmits correctly.
